signal_modulation_pipe: RTL
===========================

# signal_modulation_pipe

Parametrised, fully pipelined successor to the M-sequence signal modulator. Each cycle it accepts one sample and computes DDS_signal·2^DDS_SHIFT combined with MSEQ_signal·para_K. The combination is selected per sample by a mode field. The block converts the result to IEEE-754 single precision in RTL (no vendor IPs) and scales it by 2^-EXP_OFFSET. It sits between the M-sequence/DDS generators and the transmit path, and adds a valid handshake, signed operation and an underflow flag.

## Interface
- W, 16: width of MSEQ_signal and para_K (4..16)
- DDS_SHIFT, 10: left shift applied to DDS_signal; DDS_SHIFT+16 ≤ 2W
- EXP_OFFSET, 26: power-of-two divisor applied at float conversion (0..150)

- MSEQ_clk  in  1  clock
- MSEQ_rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input sample qualifier
- mode  in  2  0: DDS+P, 1: DDS only, 2: P only, 3: DDS−P (signed)
- MSEQ_signal  in  W  unsigned M-sequence sample
- para_K  in  W  unsigned modulation gain
- DDS_signal  in  16  unsigned DDS sample
- Signal_Send  out  32  float32 result
- Signal_Send_valid  out  1  result qualifier
- uflow  out  1  result flushed to zero by exponent underflow; qualified by Signal_Send_valid

## Operation
- P = MSEQ_signal·para_K, unsigned, 2W bits. D = DDS_signal << DDS_SHIFT, zero-extended.
- The sum S is two's complement, 2W+2 bits. No wrap is possible in any mode.
- Stage 1: register P, D, mode and valid.
- Stage 2: compute S per mode and register it.
- Stage 3: split S into a sign bit and a magnitude M (2W+1 bits). Priority-encode p = index of the MSB set in M. Register sign, M, p, a zero flag and valid.
- Stage 4: normalise and pack.
  - Exponent field e = 127 + p − EXP_OFFSET.
  - Mantissa = the 23 bits of M directly below bit p. If p < 23, left-align and zero-fill. Truncate (round toward zero); no rounding.
- Zero handling:
  - M = 0 → Signal_Send = 0x00000000, uflow = 0. Sign is forced to 0, so there is no −0 from an exact zero.
  - e ≤ 0 → Signal_Send = {sign, 31'b0}, uflow = 1. No denormals are produced.
- e ≥ 255 cannot occur for legal parameters. The implementation must assert this at elaboration.
- Fixed throughput of one sample per cycle. There is no backpressure and no stall.
- mode is sampled together with in_valid and travels with its sample. Changing mode between consecutive samples takes effect per sample.
- in_valid = 0 inserts a bubble:
  - the pipeline still advances;
  - Signal_Send and uflow hold their last valid values;
  - Signal_Send_valid = 0.

## Timing
- Latency: a sample with in_valid=1 at rising edge n gives Signal_Send_valid=1 with its data after edge n+4.
- Signal_Send_valid is in_valid delayed exactly 4 cycles. Pulse patterns, including bubbles, are preserved.
- Reset values: Signal_Send = 0x00000000, Signal_Send_valid = 0, uflow = 0, all stage valids = 0.
- Reset asserted mid-stream clears every in-flight sample and nothing emerges afterwards. The first valid output after release comes 4 cycles after the first in_valid sampled post-reset.
- Reset deassertion is synchronised externally. The block imposes no recovery cycles.
- Inputs are sampled only on edges where in_valid = 1. Input values in other cycles have no effect on outputs.

## Test plan
(W=16, DDS_SHIFT=10, EXP_OFFSET=26 unless stated)
- Zero input: mode 0, all inputs 0, single in_valid pulse → one Signal_Send_valid pulse 4 cycles later with Signal_Send=0x00000000, uflow=0.
- DDS path: DDS_signal=0x0001, MSEQ_signal=0x1234, mode 1 → Signal_Send=0x37800000 (2^-16); the product is ignored.
- Full-scale product with truncation: MSEQ_signal=0xFFFF, para_K=0xFFFF, mode 2 → Signal_Send=0x427FFE00.
- Signed mode: DDS_signal=0, MSEQ_signal=1, para_K=1024, mode 3 → 0xB7800000. Same inputs in mode 0 → 0x37800000.
- Streaming with bubbles: in_valid pattern 1,1,0,1,0,0,1 with mode cycling 0→3 and random data.
  - Required: the output valid pattern equals the input pattern delayed 4 cycles.
  - Each valid output must match the reference model bit-exactly.
  - During bubbles, Signal_Send holds its last value.
- Underflow and reset:
  - With EXP_OFFSET=140: DDS_signal=1, mode 1 → Signal_Send=0x00000000, uflow=1.
  - Separately, assert MSEQ_rst_n for 1 cycle while 3 samples are in flight → no valid output until 4 cycles after the next post-reset in_valid.

Source files
------------

// File: rtl/signal_modulation_pipe.sv
// Pipelined M-sequence/DDS modulator: combines DDS<<DDS_SHIFT with MSEQ*K per
// sample mode and emits the result as a float32 scaled by 2^-EXP_OFFSET.
module signal_modulation_pipe #(
  parameter int unsigned W          = 16,
  parameter int unsigned DDS_SHIFT  = 10,
  parameter int unsigned EXP_OFFSET = 26
) (
  input  logic          MSEQ_clk,
  input  logic          MSEQ_rst_n,
  input  logic          in_valid,
  input  logic [1:0]    mode,
  input  logic [W-1:0]  MSEQ_signal,
  input  logic [W-1:0]  para_K,
  input  logic [15:0]   DDS_signal,
  output logic [31:0]   Signal_Send,
  output logic          Signal_Send_valid,
  output logic          uflow
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned SW = 2 * W + 2;
  localparam int unsigned MW = 2 * W + 1;
  localparam int unsigned IW = $clog2(MW);
  localparam int          EXP_MAX = 127 + int'(PW) - int'(EXP_OFFSET);
  localparam logic signed [10:0] EXP_BIAS = 11'(127 - int'(EXP_OFFSET));

  if (W < 4 || W > 16) begin : g_bad_width
    $error("signal_modulation_pipe: W must be within 4..16");
  end
  if (DDS_SHIFT + 16 > PW) begin : g_bad_shift
    $error("signal_modulation_pipe: DDS_SHIFT+16 must not exceed 2W");
  end
  if (EXP_OFFSET > 150) begin : g_bad_offset
    $error("signal_modulation_pipe: EXP_OFFSET must be within 0..150");
  end
  if (EXP_MAX >= 255) begin : g_exp_overflow
    $error("signal_modulation_pipe: exponent field can reach 255");
  end

  // Stage 1: product, shifted DDS sample and sideband
  logic          s1_valid;
  logic [1:0]    s1_mode;
  logic [PW-1:0] s1_prod;
  logic [PW-1:0] s1_dds;

  always_ff @(posedge MSEQ_clk or negedge MSEQ_rst_n) begin
    if (!MSEQ_rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= '0;
      s1_prod  <= '0;
      s1_dds   <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode <= mode;
        s1_prod <= PW'(MSEQ_signal) * PW'(para_K);
        s1_dds  <= PW'(DDS_signal) << DDS_SHIFT;
      end
    end
  end

  // Stage 2: mode-selected two's complement sum
  logic          s2_valid;
  logic [SW-1:0] s2_sum;
  logic [SW-1:0] sum_c;

  always_comb begin
    sum_c = '0;
    case (s1_mode)
      2'd0:    sum_c = SW'(s1_dds) + SW'(s1_prod);
      2'd1:    sum_c = SW'(s1_dds);
      2'd2:    sum_c = SW'(s1_prod);
      default: sum_c = SW'(s1_dds) - SW'(s1_prod);
    endcase
  end

  always_ff @(posedge MSEQ_clk or negedge MSEQ_rst_n) begin
    if (!MSEQ_rst_n) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_sum <= sum_c;
    end
  end

  // Stage 3: sign/magnitude split and leading-one position
  logic          s3_valid;
  logic          s3_neg;
  logic          s3_zero;
  logic [MW-1:0] s3_mag;
  logic [IW-1:0] s3_msb;
  logic          neg_c;
  logic [MW-1:0] mag_c;
  logic [IW-1:0] msb_c;

  always_comb begin
    neg_c = s2_sum[SW-1];
    mag_c = neg_c ? MW'(~s2_sum + SW'(1)) : MW'(s2_sum);
    msb_c = '0;
    for (int i = 0; i < int'(MW); i++) begin
      if (mag_c[i]) msb_c = IW'(i);
    end
  end

  always_ff @(posedge MSEQ_clk or negedge MSEQ_rst_n) begin
    if (!MSEQ_rst_n) begin
      s3_valid <= 1'b0;
      s3_neg   <= 1'b0;
      s3_zero  <= 1'b0;
      s3_mag   <= '0;
      s3_msb   <= '0;
    end else begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_neg  <= neg_c;
        s3_zero <= (mag_c == '0);
        s3_mag  <= mag_c;
        s3_msb  <= msb_c;
      end
    end
  end

  // Stage 4: biased exponent and truncated mantissa below the leading one
  logic                s4_valid;
  logic                s4_neg;
  logic                s4_zero;
  logic signed [10:0]  s4_exp;
  logic [22:0]         s4_man;
  logic signed [10:0]  exp_c;
  logic [22:0]         man_c;

  always_comb begin
    exp_c = EXP_BIAS + 11'(s3_msb);
    man_c = 23'(({s3_mag, 23'b0} << (IW'(MW - 1) - s3_msb)) >> (MW - 1));
  end

  always_ff @(posedge MSEQ_clk or negedge MSEQ_rst_n) begin
    if (!MSEQ_rst_n) begin
      s4_valid <= 1'b0;
      s4_neg   <= 1'b0;
      s4_zero  <= 1'b0;
      s4_exp   <= '0;
      s4_man   <= '0;
    end else begin
      s4_valid <= s3_valid;
      if (s3_valid) begin
        s4_neg  <= s3_neg;
        s4_zero <= s3_zero;
        s4_exp  <= exp_c;
        s4_man  <= man_c;
      end
    end
  end

  // Output: pack, flushing exact zero and exponent underflow; hold across bubbles
  always_ff @(posedge MSEQ_clk or negedge MSEQ_rst_n) begin
    if (!MSEQ_rst_n) begin
      Signal_Send       <= '0;
      Signal_Send_valid <= 1'b0;
      uflow             <= 1'b0;
    end else begin
      Signal_Send_valid <= s4_valid;
      if (s4_valid) begin
        if (s4_zero) begin
          Signal_Send <= '0;
          uflow       <= 1'b0;
        end else if (s4_exp <= 11'sd0) begin
          Signal_Send <= {s4_neg, 31'b0};
          uflow       <= 1'b1;
        end else begin
          Signal_Send <= {s4_neg, s4_exp[7:0], s4_man};
          uflow       <= 1'b0;
        end
      end
    end
  end

endmodule
